// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction fetch bus bundle (memory side and datapath side)
//
// Purpose: groups every non-clock, non-reset signal of instruction_fetch.
//   master modport: the fetch unit itself.
//   slave modport : the environment (instruction memory plus datapath).
//
// Signal summary (direction seen from the fetch unit):
//   oMemReq        out  1   instruction-memory read request
//   oMemAddr       out  64  byte address of the request (always equals oPC)
//   iMemReady      in   1   iMemData is valid this cycle
//   iMemData       in   32  instruction word from memory
//   oValid         out  1   oInstruction/oPC hold a fetched instruction
//   oInstruction   out  32  held instruction word
//   oPC            out  64  address of the held or requested instruction
//   iAccept        in   1   datapath consumes the held instruction
//   iTakeBranch    in   1   PC-relative branch taken for the accepted instruction
//   iImmSel        in   1   0: 19-bit offset in iBranchImm[18:0]; 1: 26-bit offset
//   iBranchImm     in   26  signed word offset
//   iRedirect      in   1   register-indirect jump for the accepted instruction
//   iRedirectAddr  in   64  absolute jump target
//   oFault         out  1   sticky misaligned-target fault
//   oRetired       out  32  count of accepted instructions
interface instruction_fetch_if;
  logic        oMemReq;
  logic [63:0] oMemAddr;
  logic        iMemReady;
  logic [31:0] iMemData;
  logic        oValid;
  logic [31:0] oInstruction;
  logic [63:0] oPC;
  logic        iAccept;
  logic        iTakeBranch;
  logic        iImmSel;
  logic [25:0] iBranchImm;
  logic        iRedirect;
  logic [63:0] iRedirectAddr;
  logic        oFault;
  logic [31:0] oRetired;

  modport master (
    output oMemReq,
    output oMemAddr,
    input  iMemReady,
    input  iMemData,
    output oValid,
    output oInstruction,
    output oPC,
    input  iAccept,
    input  iTakeBranch,
    input  iImmSel,
    input  iBranchImm,
    input  iRedirect,
    input  iRedirectAddr,
    output oFault,
    output oRetired
  );

  modport slave (
    input  oMemReq,
    input  oMemAddr,
    output iMemReady,
    output iMemData,
    input  oValid,
    input  oInstruction,
    input  oPC,
    output iAccept,
    output iTakeBranch,
    output iImmSel,
    output iBranchImm,
    output iRedirect,
    output iRedirectAddr,
    input  oFault,
    input  oRetired
  );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding instruction fetch unit with branch/redirect PC update
//
// Purpose: requests one 32-bit instruction at a time from instruction memory,
//   holds it for the datapath until accepted, then computes the next PC
//   (redirect > taken branch > sequential). A misaligned redirect target
//   parks the unit in a sticky fault state until reset.
//
// Ports:
//   iCLK    in  1  clock, rising edge active
//   iReset  in  1  asynchronous active-low reset
//   bus     master modport of instruction_fetch_if (memory + datapath signals)
module instruction_fetch (
  input  logic                  iCLK,
  input  logic                  iReset,
  instruction_fetch_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [63:0] r_pc;
  logic [63:0] w_pc_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [31:0] r_retired;
  logic [31:0] w_retired_nxt;
  logic        r_fault;
  logic        w_fault_nxt;

  logic [63:0] w_seq_pc;
  logic [63:0] w_branch_off;
  logic [63:0] w_branch_pc;
  logic        w_redirect_misaligned;

  // Word offsets are sign-extended and scaled to bytes in one step; the two
  // low zero bits are the <<2.
  always_comb begin
    w_branch_off = 64'd0;
    if (bus.iImmSel) begin
      w_branch_off = {{36{bus.iBranchImm[25]}}, bus.iBranchImm, 2'b00};
    end else begin
      w_branch_off = {{43{bus.iBranchImm[18]}}, bus.iBranchImm[18:0], 2'b00};
    end
  end

  // Both additions wrap naturally at 2^64.
  assign w_seq_pc              = r_pc + 64'd4;
  assign w_branch_pc           = r_pc + w_branch_off;
  assign w_redirect_misaligned = |bus.iRedirectAddr[1:0];

  always_ff @(posedge iCLK or negedge iReset) begin
    if (!iReset) begin
      r_state   <= S_IDLE;
      r_pc      <= 64'd0;
      r_instr   <= 32'd0;
      r_retired <= 32'd0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_instr   <= w_instr_nxt;
      r_retired <= w_retired_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_instr_nxt   = r_instr;
    w_retired_nxt = r_retired;
    w_fault_nxt   = r_fault;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end

      S_FETCH: begin
        if (bus.iMemReady) begin
          w_instr_nxt = bus.iMemData;
          w_state_nxt = S_HOLD;
        end
      end

      S_HOLD: begin
        if (bus.iAccept) begin
          // The faulting instruction still counts as retired.
          w_retired_nxt = r_retired + 32'd1;
          w_state_nxt   = S_FETCH;
          if (bus.iRedirect) begin
            w_pc_nxt = bus.iRedirectAddr;
            if (w_redirect_misaligned) begin
              w_fault_nxt = 1'b1;
              w_state_nxt = S_FAULT;
            end
          end else if (bus.iTakeBranch) begin
            w_pc_nxt = w_branch_pc;
          end else begin
            w_pc_nxt = w_seq_pc;
          end
        end
      end

      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request/valid decode straight from the state register so an
  // asynchronous reset drops them without waiting for a clock edge.
  assign bus.oMemReq      = (r_state == S_FETCH);
  assign bus.oValid       = (r_state == S_HOLD);
  assign bus.oMemAddr     = r_pc;
  assign bus.oPC          = r_pc;
  assign bus.oInstruction = r_instr;
  assign bus.oRetired     = r_retired;
  assign bus.oFault       = r_fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch with a transaction-level model
module tb_instruction_fetch;

  logic iCLK;
  logic iReset;

  instruction_fetch_if bus();

  instruction_fetch dut (
    .iCLK   (iCLK),
    .iReset (iReset),
    .bus    (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_checks;
  int n_fail;

  // Reference state: address of the instruction being fetched/held and retire count.
  logic [63:0] m_pc;
  logic [31:0] m_retired;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle_inputs();
    bus.iMemReady     = 1'b0;
    bus.iMemData      = 32'd0;
    bus.iAccept       = 1'b0;
    bus.iTakeBranch   = 1'b0;
    bus.iImmSel       = 1'b0;
    bus.iBranchImm    = 26'd0;
    bus.iRedirect     = 1'b0;
    bus.iRedirectAddr = 64'd0;
  endtask

  // Called at a falling edge with iReset low; leaves the DUT requesting at PC 0.
  task automatic release_reset();
    iReset    = 1'b1;
    m_pc      = 64'd0;
    m_retired = 32'd0;
    n_checks++;
    if (bus.oMemReq !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_req: got %b want 0", bus.oMemReq);
    end
    @(negedge iCLK);
    n_checks++;
    if (bus.oMemReq !== 1'b1 || bus.oMemAddr !== 64'd0) begin
      n_fail++;
      $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", bus.oMemReq, bus.oMemAddr);
    end
  endtask

  // Precondition: at a falling edge with a request outstanding at m_pc.
  task automatic fetch(input int delay, input logic [31:0] word);
    for (int i = 0; i < delay; i++) begin
      bus.iMemReady     = 1'b0;
      bus.iMemData      = $urandom;
      bus.iAccept       = 1'($urandom);
      bus.iTakeBranch   = 1'($urandom);
      bus.iRedirect     = 1'($urandom);
      bus.iRedirectAddr = {$urandom, $urandom};
      bus.iBranchImm    = 26'($urandom);
      n_checks++;
      if (bus.oMemReq !== 1'b1 || bus.oMemAddr !== m_pc || bus.oValid !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_wait: got req=%b addr=%h valid=%b want req=1 addr=%h valid=0",
                 bus.oMemReq, bus.oMemAddr, bus.oValid, m_pc);
      end
      @(negedge iCLK);
    end
    n_checks++;
    if (bus.oMemReq !== 1'b1 || bus.oMemAddr !== m_pc) begin
      n_fail++;
      $display("FAIL fetch_req: got req=%b addr=%h want req=1 addr=%h", bus.oMemReq, bus.oMemAddr, m_pc);
    end
    bus.iMemReady = 1'b1;
    bus.iMemData  = word;
    @(negedge iCLK);
    drive_idle_inputs();
    n_checks++;
    if (bus.oValid !== 1'b1 || bus.oInstruction !== word || bus.oPC !== m_pc || bus.oMemReq !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_latch: got valid=%b instr=%h pc=%h req=%b want valid=1 instr=%h pc=%h req=0",
               bus.oValid, bus.oInstruction, bus.oPC, bus.oMemReq, word, m_pc);
    end
  endtask

  // Precondition: at a falling edge holding 'word' at m_pc. Waits, then accepts.
  task automatic hold_accept(input int wait_cycles, input logic [31:0] word,
                             input logic take, input logic immsel, input logic [25:0] imm,
                             input logic redir, input logic [63:0] raddr, output logic faulted);
    longint      off;
    logic [63:0] next_pc;
    for (int i = 0; i < wait_cycles; i++) begin
      bus.iAccept       = 1'b0;
      bus.iMemReady     = 1'($urandom);
      bus.iMemData      = $urandom;
      bus.iTakeBranch   = 1'($urandom);
      bus.iRedirect     = 1'($urandom);
      bus.iRedirectAddr = {$urandom, $urandom};
      bus.iBranchImm    = 26'($urandom);
      bus.iImmSel       = 1'($urandom);
      @(negedge iCLK);
      n_checks++;
      if (bus.oValid !== 1'b1 || bus.oInstruction !== word || bus.oPC !== m_pc || bus.oMemReq !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable: got valid=%b instr=%h pc=%h req=%b want valid=1 instr=%h pc=%h req=0",
                 bus.oValid, bus.oInstruction, bus.oPC, bus.oMemReq, word, m_pc);
      end
    end
    bus.iMemReady     = 1'($urandom);
    bus.iAccept       = 1'b1;
    bus.iTakeBranch   = take;
    bus.iImmSel       = immsel;
    bus.iBranchImm    = imm;
    bus.iRedirect     = redir;
    bus.iRedirectAddr = raddr;
    faulted = 1'b0;
    if (redir) begin
      next_pc = raddr;
      faulted = (raddr % 4) != 0;
    end else if (take) begin
      if (immsel) off = longint'($signed(imm));
      else        off = longint'($signed(imm[18:0]));
      next_pc = m_pc + 64'(off * 4);
    end else begin
      next_pc = m_pc + 64'd4;
    end
    m_retired = m_retired + 32'd1;
    m_pc      = next_pc;
    @(negedge iCLK);
    drive_idle_inputs();
    if (faulted) begin
      n_checks++;
      if (bus.oFault !== 1'b1 || bus.oMemReq !== 1'b0 || bus.oValid !== 1'b0 ||
          bus.oPC !== m_pc || bus.oRetired !== m_retired) begin
        n_fail++;
        $display("FAIL accept_fault: got fault=%b req=%b valid=%b pc=%h ret=%0d want fault=1 req=0 valid=0 pc=%h ret=%0d",
                 bus.oFault, bus.oMemReq, bus.oValid, bus.oPC, bus.oRetired, m_pc, m_retired);
      end
    end else begin
      n_checks++;
      if (bus.oMemReq !== 1'b1 || bus.oMemAddr !== m_pc || bus.oValid !== 1'b0 ||
          bus.oRetired !== m_retired || bus.oFault !== 1'b0) begin
        n_fail++;
        $display("FAIL accept_next: got req=%b addr=%h valid=%b ret=%0d fault=%b want req=1 addr=%h valid=0 ret=%0d fault=0",
                 bus.oMemReq, bus.oMemAddr, bus.oValid, bus.oRetired, bus.oFault, m_pc, m_retired);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] w;
    iReset = 1'b0;
    drive_idle_inputs();
    repeat (3) @(negedge iCLK);
    n_checks++;
    if (bus.oMemReq !== 1'b0 || bus.oValid !== 1'b0 || bus.oPC !== 64'd0 ||
        bus.oInstruction !== 32'd0 || bus.oRetired !== 32'd0 || bus.oFault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got req=%b valid=%b pc=%h instr=%h ret=%0d fault=%b want all zero",
               bus.oMemReq, bus.oValid, bus.oPC, bus.oInstruction, bus.oRetired, bus.oFault);
    end
    w = 32'd0;
    release_reset();
  endtask

  task automatic test_sequential();
    logic f;
    logic [31:0] w;
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      fetch(0, w);
      hold_accept(0, w, 1'b0, 1'b0, 26'd0, 1'b0, 64'd0, f);
    end
    n_checks++;
    if (bus.oMemAddr !== 64'd12 || bus.oRetired !== 32'd3) begin
      n_fail++;
      $display("FAIL seq_after3: got addr=%h ret=%0d want addr=c ret=3", bus.oMemAddr, bus.oRetired);
    end
  endtask

  task automatic test_mem_wait();
    logic f;
    logic [31:0] w;
    w = $urandom;
    fetch(0, w);
    hold_accept(1, w, 1'b0, 1'b0, 26'd0, 1'b0, 64'd0, f);
    w = 32'hA5A5_1234;
    fetch(3, w);
    n_checks++;
    if (bus.oPC !== 64'h10 || bus.oInstruction !== 32'hA5A5_1234) begin
      n_fail++;
      $display("FAIL mem_wait: got pc=%h instr=%h want pc=10 instr=a5a51234", bus.oPC, bus.oInstruction);
    end
    hold_accept(2, w, 1'b0, 1'b0, 26'd0, 1'b0, 64'd0, f);
  endtask

  task automatic test_branch();
    logic f;
    logic [31:0] w;
    w = $urandom;
    fetch(1, w);
    hold_accept(0, w, 1'b0, 1'b0, 26'd0, 1'b1, 64'h100, f);
    w = $urandom;
    fetch(0, w);
    hold_accept(1, w, 1'b1, 1'b0, 26'h007FFFE, 1'b0, 64'd0, f);
    n_checks++;
    if (bus.oMemAddr !== 64'hF8) begin
      n_fail++;
      $display("FAIL branch_cb: got addr=%h want f8", bus.oMemAddr);
    end
    w = $urandom;
    fetch(0, w);
    hold_accept(0, w, 1'b0, 1'b0, 26'd0, 1'b1, 64'h100, f);
    w = $urandom;
    fetch(2, w);
    hold_accept(0, w, 1'b1, 1'b1, 26'h0000010, 1'b0, 64'd0, f);
    n_checks++;
    if (bus.oMemAddr !== 64'h140) begin
      n_fail++;
      $display("FAIL branch_b: got addr=%h want 140", bus.oMemAddr);
    end
  endtask

  task automatic test_wrap();
    logic f;
    logic [31:0] w;
    w = $urandom;
    fetch(0, w);
    hold_accept(0, w, 1'b0, 1'b0, 26'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, f);
    w = $urandom;
    fetch(1, w);
    // Preload the retire counter just below wrap.
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    m_retired = 32'hFFFF_FFFF;
    hold_accept(0, w, 1'b0, 1'b0, 26'd0, 1'b0, 64'd0, f);
    n_checks++;
    if (bus.oMemAddr !== 64'd0 || bus.oRetired !== 32'd0) begin
      n_fail++;
      $display("FAIL wrap: got addr=%h ret=%h want addr=0 ret=0", bus.oMemAddr, bus.oRetired);
    end
  endtask

  task automatic test_random();
    logic f;
    logic [31:0] w;
    int kind;
    for (int i = 0; i < 150; i++) begin
      w = $urandom;
      fetch($urandom_range(0, 3), w);
      kind = $urandom_range(0, 3);
      case (kind)
        0: hold_accept($urandom_range(0, 3), w, 1'b0, 1'($urandom), 26'($urandom), 1'b0, 64'd0, f);
        1: hold_accept($urandom_range(0, 3), w, 1'b1, 1'b0, 26'($urandom), 1'b0, 64'd0, f);
        2: hold_accept($urandom_range(0, 3), w, 1'b1, 1'b1, 26'($urandom), 1'b0, 64'd0, f);
        default: hold_accept($urandom_range(0, 3), w, 1'($urandom), 1'($urandom), 26'($urandom),
                             1'b1, {$urandom, $urandom} & ~64'd3, f);
      endcase
      if (f) begin
        n_checks++;
        n_fail++;
        $display("FAIL random_fault: got fault on aligned stream want none");
      end
    end
  endtask

  task automatic test_redirect_fault();
    logic f;
    logic [31:0] w;
    w = $urandom;
    fetch(0, w);
    hold_accept(0, w, 1'b1, 1'b0, 26'h1, 1'b1, 64'h2000, f);
    n_checks++;
    if (bus.oMemAddr !== 64'h2000) begin
      n_fail++;
      $display("FAIL redirect_prio: got addr=%h want 2000", bus.oMemAddr);
    end
    w = $urandom;
    fetch(0, w);
    hold_accept(1, w, 1'b1, 1'b0, 26'h1, 1'b1, 64'h2002, f);
    for (int i = 0; i < 5; i++) begin
      bus.iMemReady = 1'b1;
      bus.iAccept   = 1'b1;
      bus.iRedirect = 1'($urandom);
      bus.iRedirectAddr = {$urandom, $urandom};
      @(negedge iCLK);
      n_checks++;
      if (bus.oFault !== 1'b1 || bus.oMemReq !== 1'b0 || bus.oValid !== 1'b0 ||
          bus.oPC !== 64'h2002 || bus.oRetired !== m_retired) begin
        n_fail++;
        $display("FAIL fault_sticky: got fault=%b req=%b valid=%b pc=%h ret=%0d want fault=1 req=0 valid=0 pc=2002 ret=%0d",
                 bus.oFault, bus.oMemReq, bus.oValid, bus.oPC, bus.oRetired, m_retired);
      end
    end
    drive_idle_inputs();
  endtask

  task automatic test_reset_in_hold();
    logic [31:0] w;
    // Reset out of FAULT clears the sticky flag without a clock edge.
    #2;
    iReset = 1'b0;
    #1;
    n_checks++;
    if (bus.oFault !== 1'b0 || bus.oPC !== 64'd0 || bus.oRetired !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_fault: got fault=%b pc=%h ret=%0d want 0 0 0", bus.oFault, bus.oPC, bus.oRetired);
    end
    @(negedge iCLK);
    release_reset();
    w = $urandom;
    fetch(1, w);
    bus.iAccept     = 1'b1;
    bus.iTakeBranch = 1'b1;
    bus.iBranchImm  = 26'h40;
    #2;
    iReset = 1'b0;
    #1;
    n_checks++;
    if (bus.oValid !== 1'b0 || bus.oRetired !== 32'd0 || bus.oMemReq !== 1'b0 ||
        bus.oPC !== 64'd0 || bus.oInstruction !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got valid=%b ret=%0d req=%b pc=%h instr=%h want all zero",
               bus.oValid, bus.oRetired, bus.oMemReq, bus.oPC, bus.oInstruction);
    end
    @(negedge iCLK);
    drive_idle_inputs();
    release_reset();
    w = $urandom;
    fetch(0, w);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    iReset   = 1'b0;
    m_pc     = 64'd0;
    m_retired = 32'd0;
    drive_idle_inputs();
    @(negedge iCLK);
    test_reset();
    test_sequential();
    test_mem_wait();
    test_branch();
    test_wrap();
    test_random();
    test_redirect_fault();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
